stopwatch_control: RTL and testbench



---
 rtl/stopwatch_control_if.sv | 23 ++
 rtl/stopwatch_control.sv | 134 +++++++++++++
 tb/tb_stopwatch_control.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_control_if.sv
// Button-side and display-side signals of the stopwatch controller.
// The controller uses the slave modport; the stimulus side uses master.
interface stopwatch_control_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic       running;
  logic       overflow;
  logic       tick;
  logic [7:0] disp_min;
  logic [7:0] disp_sec;
  logic [7:0] disp_cs;

  modport master (
    output start_stop, clear, lap,
    input  running, overflow, tick, disp_min, disp_sec, disp_cs
  );

  modport slave (
    input  start_stop, clear, lap,
    output running, overflow, tick, disp_min, disp_sec, disp_cs
  );
endinterface

// File: rtl/stopwatch_control.sv
// Stopwatch sequencer: start/stop/clear FSM, 1/100 s prescaler, BCD mm:ss.cc count.
// Define LAP_HOLD_EN to build the lap hold that freezes disp_* while counting continues.
module stopwatch_control #(
  parameter int unsigned TICK_DIVISOR = 500000
) (
  input  logic               clock,
  input  logic               reset_n,
  stopwatch_control_if.slave sw
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_OVF} state_t;

  localparam logic [23:0] PRESC_LAST = 24'(TICK_DIVISOR - 1);
  // Per-digit top values, packed {min_t, min_u, sec_t, sec_u, cs_t, cs_u}.
  localparam logic [23:0] COUNT_MAX  = 24'h595999;

  state_t      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [23:0] count_q, count_d;
  logic [23:0] disp_q, disp_d;
  logic        running_q;
  logic        overflow_q;
  logic        tick_q;
  logic        tick_now;
  logic        clear_acc;
  logic [23:0] count_inc;
  logic [6:0]  carry;

  // Ripple carry through the six BCD digits; carry[6] means the count is at 59:59.99.
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    logic [3:0] digit;
    logic       at_top;
    assign digit       = count_q[gi*4 +: 4];
    assign at_top      = (digit == COUNT_MAX[gi*4 +: 4]);
    assign carry[gi+1] = carry[gi] & at_top;
    assign count_inc[gi*4 +: 4] = !carry[gi] ? digit :
                                  (at_top ? 4'd0 : digit + 4'd1);
  end

  assign tick_now  = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
  assign clear_acc = sw.clear && ((state_q == ST_PAUSE) || (state_q == ST_OVF));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (sw.start_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        presc_d = tick_now ? 24'd0 : presc_q + 24'd1;
        // The tick is applied first; saturation outranks a coincident start_stop.
        if (tick_now && carry[6]) begin
          state_d = ST_OVF;
        end else begin
          if (tick_now) count_d = count_inc;
          if (sw.start_stop) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!sw.clear && sw.start_stop) state_d = ST_RUN;
      end
      default: begin
      end
    endcase
    if (clear_acc) begin
      state_d = ST_IDLE;
      presc_d = 24'd0;
      count_d = 24'd0;
    end
  end

`ifdef LAP_HOLD_EN
  logic hold_q, hold_d;
  logic capture;

  always_comb begin
    hold_d  = hold_q;
    capture = 1'b0;
    if (clear_acc) begin
      hold_d = 1'b0;
    end else if (sw.lap) begin
      if (hold_q && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
        hold_d = 1'b0;
      end else if (!hold_q && (state_q == ST_RUN)) begin
        hold_d  = 1'b1;
        capture = 1'b1;
      end
    end
    // Capture takes count_q, i.e. the value before any tick on this edge.
    if (capture)     disp_d = count_q;
    else if (hold_d) disp_d = disp_q;
    else             disp_d = count_d;
  end
`else
  logic unused_lap;
  assign unused_lap = sw.lap;
  assign disp_d     = count_d;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= 24'd0;
      count_q    <= 24'd0;
      disp_q     <= 24'd0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
      tick_q     <= 1'b0;
`ifdef LAP_HOLD_EN
      hold_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      disp_q     <= disp_d;
      running_q  <= (state_d == ST_RUN);
      overflow_q <= (state_d == ST_OVF);
      tick_q     <= tick_now;
`ifdef LAP_HOLD_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign sw.running  = running_q;
  assign sw.overflow = overflow_q;
  assign sw.tick     = tick_q;
  assign sw.disp_min = disp_q[23:16];
  assign sw.disp_sec = disp_q[15:8];
  assign sw.disp_cs  = disp_q[7:0];
endmodule

// File: tb/tb_stopwatch_control.sv
// Scoreboard bench for stopwatch_control (TICK_DIVISOR=4): an integer centisecond
// model queues expected outputs per driven cycle; a monitor compares after each edge.
module tb_stopwatch_control;
  localparam int DIV  = 4;
  localparam int MAXC = 359999;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVF = 3;
`ifdef LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [26:0] val;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [23:0] force_val;
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_state, m_presc, m_cnt, m_held;
  bit          m_hold;

  stopwatch_control_if sw();

  stopwatch_control #(.TICK_DIVISOR(DIV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .sw      (sw)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    int mn, sc, cs;
    mn = v / 6000;
    sc = (v / 100) % 60;
    cs = v % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic logic [26:0] obs();
    return {sw.running, sw.overflow, sw.tick, sw.disp_min, sw.disp_sec, sw.disp_cs};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_presc = 0;
    m_cnt   = 0;
    m_hold  = 1'b0;
    m_held  = 0;
  endtask

  task automatic model_step(input logic ss, input logic clr, input logic lp, input string tag);
    bit   tick    = 1'b0;
    bit   clr_acc = 1'b0;
    bit   do_lap;
    exp_t e;
    do_lap = lp && LAP_EN;
    case (m_state)
      S_IDLE: if (ss) m_state = S_RUN;
      S_RUN: begin
        if (do_lap) begin
          if (m_hold) m_hold = 1'b0;
          else begin m_hold = 1'b1; m_held = m_cnt; end
        end
        if (m_presc == DIV - 1) begin
          m_presc = 0;
          tick = 1'b1;
          if (m_cnt == MAXC) m_state = S_OVF;
          else m_cnt++;
        end else begin
          m_presc++;
        end
        if (ss && m_state == S_RUN) m_state = S_PAUSE;
      end
      S_PAUSE: begin
        if (clr) clr_acc = 1'b1;
        else begin
          if (ss) m_state = S_RUN;
          if (do_lap && m_hold) m_hold = 1'b0;
        end
      end
      default: if (clr) clr_acc = 1'b1;
    endcase
    if (clr_acc) begin
      m_state = S_IDLE;
      m_presc = 0;
      m_cnt   = 0;
      m_hold  = 1'b0;
    end
    e.tag = tag;
    e.val = {m_state == S_RUN, m_state == S_OVF, tick, to_bcd(m_hold ? m_held : m_cnt)};
    exp_q.push_back(e);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("t=%0t %s obs=%h exp=%h", $time, e.tag, obs(), e.val);
      check_val(e.tag, 32'(obs()), 32'(e.val));
    end
  end

  task automatic step(input logic ss, input logic clr, input logic lp, input string tag);
    sw.start_stop = ss;
    sw.clear      = clr;
    sw.lap        = lp;
    model_step(ss, clr, lp, tag);
    @(posedge clock);
    #2;
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    sw.lap        = 1'b0;
  endtask

  task automatic run_until(input int target, input string tag);
    int guard = 0;
    while (m_cnt != target && guard < 2000) begin
      step(1'b0, 1'b0, 1'b0, tag);
      guard++;
    end
    check_val({tag, "_reached"}, m_cnt, target);
  endtask

  // Only used while paused, so no tick edge falls inside the forced window.
  task automatic preload(input int value);
    force_val = to_bcd(value);
    force dut.count_q = force_val;
    m_cnt = value;
    step(1'b0, 1'b0, 1'b0, "preload");
    release dut.count_q;
  endtask

  initial begin
    int  lat;
    bit  got;
    int  guard;
    reset_n       = 1'b0;
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    sw.lap        = 1'b0;
    force_val     = '0;
    model_reset();
    #2;
    check_val("reset_state", 32'(obs()), 32'd0);
    #5;
    reset_n = 1'b1;

    // Asynchronous reset in the middle of a run.
    step(1'b1, 1'b0, 1'b0, "t1_start");
    run_until(5, "t1_run");
    check_val("t1_cs_before_reset", sw.disp_cs, 8'h05);
    reset_n = 1'b0;
    #1;
    check_val("t1_async_reset", 32'(obs()), 32'd0);
    model_reset();
    @(posedge clock);
    #2;
    check_val("t1_reset_held", 32'(obs()), 32'd0);
    reset_n = 1'b1;

    // Tick cadence from start.
    step(1'b1, 1'b0, 1'b0, "t2_start");
    for (int c = 1; c <= 41; c++) begin
      step(1'b0, 1'b0, 1'b0, "t2_run");
      check_val("t2_tick_phase", sw.tick, (c % 4 == 0) ? 32'd1 : 32'd0);
    end
    check_val("t2_cs_at_41", sw.disp_cs, 8'h10);
    step(1'b1, 1'b0, 1'b0, "t2_pause");
    step(1'b0, 1'b1, 1'b0, "t2_clear");

    // Pause keeps sub-tick phase; clear beats start_stop in PAUSE.
    step(1'b1, 1'b0, 1'b0, "t3_start");
    step(1'b0, 1'b0, 1'b0, "t3_run");
    step(1'b1, 1'b0, 1'b0, "t3_pause");
    repeat (100) step(1'b0, 1'b0, 1'b0, "t3_hold");
    check_val("t3_paused_running", sw.running, 1'b0);
    step(1'b1, 1'b0, 1'b0, "t3_resume");
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      step(1'b0, 1'b0, 1'b0, "t3_wait");
      if (sw.tick) begin got = 1'b1; lat = i; end
    end
    check_val("t3_resume_tick_lat", lat, 2);
    check_val("t3_cs_after_tick", sw.disp_cs, 8'h01);
    step(1'b1, 1'b0, 1'b0, "t3_pause2");
    step(1'b1, 1'b1, 1'b0, "t3_clear_and_ss");
    check_val("t3_idle_zero", 32'(obs()), 32'd0);

    // clear is ignored while running.
    step(1'b1, 1'b0, 1'b0, "t5_start");
    run_until(3, "t5_run");
    step(1'b0, 1'b1, 1'b0, "t5_clear_in_run");
    run_until(4, "t5_run2");
    check_val("t5_still_running", sw.running, 1'b1);
    check_val("t5_cs", sw.disp_cs, 8'h04);
    step(1'b1, 1'b0, 1'b0, "t5_pause");
    step(1'b0, 1'b1, 1'b0, "t5_clear");

    // Carry chain and saturation.
    step(1'b1, 1'b0, 1'b0, "t4_start");
    run_until(99, "t4_run99");
    check_val("t4_cs_99", sw.disp_cs, 8'h99);
    run_until(100, "t4_carry_sec");
    check_val("t4_sec_01", {sw.disp_sec, sw.disp_cs}, 16'h0100);
    step(1'b1, 1'b0, 1'b0, "t4_pause_a");
    preload(5999);
    step(1'b1, 1'b0, 1'b0, "t4_resume_a");
    run_until(6000, "t4_carry_min");
    check_val("t4_min_01", {sw.disp_min, sw.disp_sec, sw.disp_cs}, 24'h010000);
    step(1'b1, 1'b0, 1'b0, "t4_pause_b");
    preload(59999);
    step(1'b1, 1'b0, 1'b0, "t4_resume_b");
    run_until(60000, "t4_carry_min_tens");
    check_val("t4_min_10", {sw.disp_min, sw.disp_sec, sw.disp_cs}, 24'h100000);
    step(1'b1, 1'b0, 1'b0, "t4_pause_c");
    preload(MAXC);
    step(1'b1, 1'b0, 1'b0, "t4_resume_c");
    guard = 0;
    while (m_state != S_OVF && guard < 20) begin
      step(1'b0, 1'b0, 1'b0, "t4_to_ovf");
      guard++;
    end
    check_val("t4_overflow", sw.overflow, 1'b1);
    check_val("t4_not_running", sw.running, 1'b0);
    check_val("t4_saturated", {sw.disp_min, sw.disp_sec, sw.disp_cs}, 24'h595999);
    step(1'b1, 1'b0, 1'b0, "t4_ss_ignored");
    repeat (5) step(1'b0, 1'b0, 1'b0, "t4_ovf_hold");
    check_val("t4_still_ovf", sw.overflow, 1'b1);
    step(1'b0, 1'b1, 1'b0, "t4_clear");
    check_val("t4_idle_zero", 32'(obs()), 32'd0);

    // Lap hold (ignored when the feature is not built).
    step(1'b1, 1'b0, 1'b0, "t6_start");
    run_until(7, "t6_run7");
    step(1'b0, 1'b0, 1'b1, "t6_lap");
    check_val("t6_lap_capture", sw.disp_cs, 8'h07);
    run_until(15, "t6_run15");
    check_val("t6_held", sw.disp_cs, LAP_EN ? 8'h07 : 8'h15);
    step(1'b0, 1'b0, 1'b1, "t6_lap_release");
    check_val("t6_released", sw.disp_cs, 8'h15);
    step(1'b1, 1'b0, 1'b0, "t6_pause");
    step(1'b0, 1'b1, 1'b0, "t6_clear");

    @(posedge clock);
    #2;
    check_val("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
